// File: rtl/seg7_capture.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus and emits one word per scan.
// Optional macro SEG7CAP_BLANK_EN: pattern 7F decodes as a blank digit instead of an error.
module seg7_capture #(
   parameter int unsigned NDIGITS = 8,
   parameter int unsigned STABLE  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [6:0]             seg_n,
   input  logic [NDIGITS-1:0]     an_n,
   output logic [4*NDIGITS-1:0]   value,
   output logic [NDIGITS-1:0]     err_mask,
   output logic [NDIGITS-1:0]     blank_mask,
   output logic                   valid,
   input  logic                   ready,
   output logic                   overrun
);

   localparam logic [7:0] StableC = 8'(STABLE);
   localparam logic [7:0] CapAt   = 8'(STABLE - 2);

   logic [6:0]           seg_q;
   logic [NDIGITS-1:0]   an_q;
   logic [7:0]           cnt_q, cnt_d;
   logic [NDIGITS-1:0]   sel, newcap, captured_q, captured_d;
   logic                 legal, same, capture, complete;
   logic [3:0]           dec_nib;
   logic                 dec_err, dec_blank;
   logic [4*NDIGITS-1:0] slot_val_q, slot_val_d;
   logic [NDIGITS-1:0]   slot_err_q, slot_err_d, slot_blank_q, slot_blank_d;

   // Counting runs on the sample being registered this edge, so the STABLE-th identical sample
   // is recognised at the same edge that registers it.
   assign sel     = ~an_n;
   assign legal   = (sel != '0) && ((sel & (sel - NDIGITS'(1))) == '0);
   assign same    = ({an_n, seg_n} == {an_q, seg_q});
   assign capture = legal && same && (cnt_q == CapAt);
   assign newcap  = capture ? sel : '0;
   assign complete = &(captured_q | newcap);

   always_comb begin
      if (!legal || !same) begin
         cnt_d = '0;
      end else if (cnt_q < StableC) begin
         cnt_d = cnt_q + 8'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // seg_q equals the incoming pattern whenever capture is asserted.
   always_comb begin
      dec_nib   = 4'h0;
      dec_err   = 1'b0;
      dec_blank = 1'b0;
      case (seg_q)
         7'h40: dec_nib = 4'h0;
         7'h79: dec_nib = 4'h1;
         7'h24: dec_nib = 4'h2;
         7'h30: dec_nib = 4'h3;
         7'h19: dec_nib = 4'h4;
         7'h12: dec_nib = 4'h5;
         7'h02: dec_nib = 4'h6;
         7'h78: dec_nib = 4'h7;
         7'h00: dec_nib = 4'h8;
         7'h10: dec_nib = 4'h9;
         7'h08: dec_nib = 4'hA;
         7'h03: dec_nib = 4'hB;
         7'h46: dec_nib = 4'hC;
         7'h21: dec_nib = 4'hD;
         7'h06: dec_nib = 4'hE;
         7'h0E: dec_nib = 4'hF;
`ifdef SEG7CAP_BLANK_EN
         7'h7F: dec_blank = 1'b1;
`endif
         default: dec_err = 1'b1;
      endcase
   end

   always_comb begin
      slot_val_d   = slot_val_q;
      slot_err_d   = slot_err_q;
      slot_blank_d = slot_blank_q;
      for (int unsigned i = 0; i < NDIGITS; i++) begin
         if (newcap[i]) begin
            slot_val_d[4*i +: 4] = dec_nib;
            slot_err_d[i]        = dec_err;
            slot_blank_d[i]      = dec_blank;
         end
      end
      captured_d = complete ? '0 : (captured_q | newcap);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg_q        <= '1;
         an_q         <= '1;
         cnt_q        <= '0;
         captured_q   <= '0;
         slot_val_q   <= '0;
         slot_err_q   <= '0;
         slot_blank_q <= '0;
      end else begin
         seg_q        <= seg_n;
         an_q         <= an_n;
         cnt_q        <= cnt_d;
         captured_q   <= captured_d;
         slot_val_q   <= slot_val_d;
         slot_err_q   <= slot_err_d;
         slot_blank_q <= slot_blank_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value      <= '0;
         err_mask   <= '0;
         blank_mask <= '0;
         valid      <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (complete && (!valid || ready)) begin
            value      <= slot_val_d;
            err_mask   <= slot_err_d;
            blank_mask <= slot_blank_d;
            valid      <= 1'b1;
         end else if (complete) begin
            overrun <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Sequential inverse of the hex-to-seven-segment display path. Monitors a multiplexed, active-low seven-segment display bus (segment lines plus active-low digit selects) and debounces each digit's pattern. It decodes each pattern back to a hex nibble and assembles one word per full scan. The word is delivered on a valid/ready handshake, for board-level loopback checks of the display output and for self-test of the debug display.

## Interface
- `NDIGITS`, 8: number of multiplexed digits; `value` width is 4*NDIGITS.
- `STABLE`, 4: consecutive identical samples required to accept a digit; legal range 2..255.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `seg_n`  in  7: segment lines, active-low, bit6=g .. bit0=a.
- `an_n`  in  NDIGITS: digit selects, active-low, one-hot-low when legal.
- `value`  out  4*NDIGITS: decoded word; digit i in bits [4i+3:4i].
- `err_mask`  out  NDIGITS: bit i set when digit i held an undecodable pattern.
- `blank_mask`  out  NDIGITS: bit i set when digit i was blank (see Configuration).
- `valid`  out  1: `value`/masks hold an unconsumed frame.
- `ready`  in  1: consumer accepts the frame when `valid && ready`.
- `overrun`  out  1: one-cycle pulse when a completed frame is dropped.

## Operation
- One clock and one reset: synchronous, active-high. On `reset`:
  - `value`, `err_mask`, `blank_mask`, `valid` and `overrun` are 0.
  - Captured-slot flags are cleared.
  - Stability counter is 0.
  - Sample registers are set to all-ones (no digit selected).
- **Input stage:** `seg_n` and `an_n` are registered once every cycle.
- **Stability tracking:**
  - The counter clears when the registered {an_n, seg_n} differs from the previous registered value.
  - The counter also clears when `an_n` is not exactly one-hot-low (zero or multiple digits low).
  - Otherwise the counter increments, saturating at STABLE.
- **Digit capture:**
  - Trigger: the counter transitions STABLE-2 to STABLE-1, i.e. the STABLE-th identical legal sample is seen.
  - Action: slot i (the low `an_n` bit) is written and `captured[i]` is set.
  - Exactly one capture per dwell.
  - Re-capture of an already captured slot before the frame completes overwrites it (latest wins).
- **Decode (seg_n hex → nibble):**
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
  - Any other pattern gives nibble 0 and sets the slot error bit.
- **Frame completion:**
  - Trigger: `captured | new_capture` is all ones.
  - If `valid==0`, or `valid && ready` in this cycle, the slots load into the outputs, `valid` is 1 and `captured` clears.
  - If `valid && !ready`, the frame is discarded, `captured` clears, `overrun` pulses for one cycle and the outputs hold.
- **Handshake:**
  - `valid` stays high with stable outputs until `ready`.
  - `valid && ready` without a new completion drops `valid` on the next edge.
  - `ready` while `valid==0` is ignored.
- **Reset mid-frame:** partial slots are discarded, and any pending output frame is lost.

## Timing
- Pins steady and legal for cycles t..t+STABLE-1: registered at edges t+1..t+STABLE; slot written at edge t+STABLE.
- Frame output: if that capture completes the frame, `valid` rises and `value` updates at that same edge t+STABLE.
- Minimum digit dwell at the pins: STABLE cycles. A shorter dwell is never captured.
- A single-cycle glitch inside a dwell restarts counting. The digit captures once more after the glitch, with an identical value.
- Throughput: one frame per NDIGITS*STABLE cycles minimum.
- `overrun` is high only in the cycle after the dropping edge, never two consecutive cycles unless two frames drop.

## Configuration
- `SEG7CAP_BLANK_EN` defined: pattern 7F (all segments off) decodes to nibble 0, sets `blank_mask[i]` and does not set `err_mask[i]`.
- Undefined: 7F is an ordinary invalid pattern (err bit set), and `blank_mask` is tied to 0.

## Test plan
All scenarios use NDIGITS=4 and STABLE=4.
- **Full scan:** digits 0..3 driven 30,24,79,40 for 6 cycles each, ready=1 → value=16'h0123, err_mask=0, valid pulses 1 cycle at the expected edge.
- **Short dwell:** digit 2 held 3 cycles, then digit 2 held 4 cycles with 08 → only the second dwell captures; value[11:8]=A.
- **Invalid, blank, illegal select:**
  - Pattern 7F on digit 1 → err_mask=4'b0010 without the macro; blank_mask=4'b0010 and err_mask=0 with `SEG7CAP_BLANK_EN`.
  - an_n=4'b1100 → no capture.
- **Backpressure:** ready=0, two complete scans → first frame held, overrun pulses once, value unchanged; then ready=1 → valid drops next cycle.
- **Simultaneous consume/complete:** ready=1 at the edge a new frame completes → valid stays 1 and value changes to the new frame.
- **Reset:** reset after 2 of 4 digits → all outputs 0; a subsequent full scan yields a frame with no stale slots.
